// File: rtl/temp_control_core_pkg.sv
// temp_ctrl_pkg: shared types and field positions for the temperature control core.
//   state_t        supervisor state encoding (also reported in status[1:0])
//   CTRL_*         bit indices in ctrl_reg
//   HYST_* / KP_*  field slices in hyst_reg
//   STAT_*         bit positions in the status word
package temp_ctrl_pkg;

    localparam logic [1:0] STATE_DISABLED = 2'd0;
    localparam logic [1:0] STATE_REGULATE = 2'd1;
    localparam logic [1:0] STATE_FAULT    = 2'd2;

    typedef enum logic [1:0] {
        ST_DISABLED = STATE_DISABLED,
        ST_REGULATE = STATE_REGULATE,
        ST_FAULT    = STATE_FAULT
    } state_t;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;

    localparam int HYST_LSB = 0;
    localparam int HYST_MSB = 15;
    localparam int KP_LSB   = 16;
    localparam int KP_MSB   = 23;

    localparam int STAT_STATE_LSB  = 0;
    localparam int STAT_STATE_MSB  = 1;
    localparam int STAT_HEAT       = 2;
    localparam int STAT_TOUT       = 3;
    localparam int STAT_OTEMP      = 4;
    localparam int STAT_SAMPLE_LSB = 16;
    localparam int STAT_SAMPLE_MSB = 31;

endpackage

// File: rtl/temp_control_core_if.sv
// temp_ctrl_if: register, sample-stream and result signals between the
// AXI4-Lite register block (master) and the control core (slave).
//   ctrl_reg/setpoint_reg/hyst_reg/limit_reg  register file contents
//   temp_valid/temp_data                      streamed temperature sample
//   heater_pwm/alarm/status                   core results
interface temp_ctrl_if #(
    parameter int TEMP_W = 16
);
    import temp_ctrl_pkg::*;

    logic [31:0]              ctrl_reg;
    logic [31:0]              setpoint_reg;
    logic [31:0]              hyst_reg;
    logic [31:0]              limit_reg;
    logic                     temp_valid;
    logic signed [TEMP_W-1:0] temp_data;
    logic                     heater_pwm;
    logic                     alarm;
    logic [31:0]              status;

    modport master (
        output ctrl_reg, setpoint_reg, hyst_reg, limit_reg, temp_valid, temp_data,
        input  heater_pwm, alarm, status
    );

    modport slave (
        input  ctrl_reg, setpoint_reg, hyst_reg, limit_reg, temp_valid, temp_data,
        output heater_pwm, alarm, status
    );
endinterface

// File: rtl/temp_pwm_gen.sv
// temp_pwm_gen: heater PWM generator.
//   ACLK, ARESET  clock, asynchronous active-high reset
//   run           1 while the supervisor will be regulating after this edge
//   duty_target   requested high cycles per period (0..PWM_PERIOD)
//   pwm           registered heater drive
// The duty is only picked up at the period wrap and on the first run cycle,
// so a target change never truncates or stretches a period in progress.
module temp_pwm_gen
    import temp_ctrl_pkg::*;
#(
    parameter int PWM_PERIOD = 1000,
    parameter int DUTY_W     = $clog2(PWM_PERIOD + 1)
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              run,
    input  logic [DUTY_W-1:0] duty_target,
    output logic              pwm
);
    localparam int              CNT_W = $clog2(PWM_PERIOD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PWM_PERIOD - 1);

    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [DUTY_W-1:0] duty, duty_nx;
    logic              run_q;

    always_comb begin
        cnt_nx  = '0;
        duty_nx = '0;
        if (!run) begin
            cnt_nx  = '0;
            duty_nx = '0;
        end else if (!run_q || cnt == LAST) begin
            cnt_nx  = '0;
            duty_nx = duty_target;
        end else begin
            cnt_nx  = cnt + 1'b1;
            duty_nx = duty;
        end
    end

    // Output is compared against the post-edge counter so pwm stays aligned
    // with the counter value it belongs to.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cnt   <= '0;
            duty  <= '0;
            run_q <= 1'b0;
            pwm   <= 1'b0;
        end else begin
            cnt   <= cnt_nx;
            duty  <= duty_nx;
            run_q <= run;
            pwm   <= run && (DUTY_W'(cnt_nx) < duty_nx);
        end
    end
endmodule

// File: rtl/temp_control_core.sv
// temp_control_core: supervisor FSM, regulation arithmetic and status word.
//   ACLK, ARESET  clock, asynchronous active-high reset
//   bus           temp_ctrl_if.slave: registers and sample in; heater_pwm,
//                 alarm and status out
//
// state    | meaning
// DISABLED | enable low; heater off, counters and sample cleared
// REGULATE | heater driven from the latest sample, supervision active
// FAULT    | overtemp or sensor timeout; heater off until enable drops
module temp_control_core
    import temp_ctrl_pkg::*;
#(
    parameter int TEMP_W      = 16,
    parameter int PWM_PERIOD  = 1000,
    parameter int KP_SHIFT    = 4,
    parameter int ALARM_CNT   = 3,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic     ACLK,
    input  logic     ARESET,
    temp_ctrl_if.slave bus
);
    localparam int DUTY_W = $clog2(PWM_PERIOD + 1);
    localparam int ACNT_W = $clog2(ALARM_CNT + 1);
    localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam int PW     = TEMP_W + 10;
    localparam logic signed [PW-1:0] P_S = PW'(PWM_PERIOD);
    localparam logic [DUTY_W-1:0]    DUTY_FULL = DUTY_W'(PWM_PERIOD);

    state_t                   state;
    logic                     heating, tout_cause, otemp_cause, alarm_q;
    logic signed [TEMP_W-1:0] last_sample;
    logic [DUTY_W-1:0]        target;
    logic [ACNT_W-1:0]        alarm_cnt;
    logic [TCNT_W-1:0]        tout_cnt;

    logic                     enable, mode;
    logic signed [TEMP_W-1:0] sp, temp, limit;
    logic [15:0]              hyst;
    logic [7:0]               kp;
    logic                     unused_bits;

    assign enable = bus.ctrl_reg[CTRL_EN];
    assign mode   = bus.ctrl_reg[CTRL_MODE];
    assign sp     = bus.setpoint_reg[TEMP_W-1:0];
    assign limit  = bus.limit_reg[TEMP_W-1:0];
    assign temp   = bus.temp_data;
    assign hyst   = bus.hyst_reg[HYST_MSB:HYST_LSB];
    assign kp     = bus.hyst_reg[KP_MSB:KP_LSB];
    assign unused_bits = ^{bus.ctrl_reg[31:2], bus.setpoint_reg[31:TEMP_W],
                           bus.hyst_reg[31:24], bus.limit_reg[31:TEMP_W]};

    // Hysteresis band, two guard bits so setpoint +/- hyst cannot wrap.
    logic signed [TEMP_W+1:0] temp_x, sp_x, hyst_x, band_lo, band_hi;
    logic                     heat_hyst;
    assign temp_x    = {{2{temp[TEMP_W-1]}}, temp};
    assign sp_x      = {{2{sp[TEMP_W-1]}}, sp};
    assign hyst_x    = {{(TEMP_W - 14){1'b0}}, hyst};
    assign band_lo   = sp_x - hyst_x;
    assign band_hi   = sp_x + hyst_x;
    assign heat_hyst = (temp_x < band_lo) ? 1'b1 : (temp_x > band_hi) ? 1'b0 : heating;

    // Proportional path.
    logic signed [TEMP_W:0] err;
    logic signed [PW-1:0]   err_x, kp_x, prod, p_val;
    logic [DUTY_W-1:0]      p_target, target_nx;
    logic                   heat_nx;
    assign err   = {sp[TEMP_W-1], sp} - {temp[TEMP_W-1], temp};
    assign err_x = {{(PW - TEMP_W - 1){err[TEMP_W]}}, err};
    assign kp_x  = {{(PW - 8){1'b0}}, kp};
    assign prod  = err_x * kp_x;
    assign p_val = prod >>> KP_SHIFT;

    always_comb begin
        p_target = '0;
        if (p_val <= 0)        p_target = '0;
        else if (p_val >= P_S) p_target = DUTY_FULL;
        else                   p_target = p_val[DUTY_W-1:0];
    end

    assign target_nx = mode ? p_target : (heat_hyst ? DUTY_FULL : '0);
    assign heat_nx   = mode ? (p_target != '0) : heat_hyst;

    // Supervision, evaluated against the values the edge will commit.
    logic              over, otemp_hit, tout_hit, fault_hit, run;
    logic [ACNT_W-1:0] acnt_inc;
    assign over      = temp >= limit;
    assign acnt_inc  = (alarm_cnt == ACNT_W'(ALARM_CNT)) ? alarm_cnt : alarm_cnt + 1'b1;
    assign otemp_hit = (state == ST_REGULATE) && bus.temp_valid && over &&
                       (acnt_inc == ACNT_W'(ALARM_CNT));
    assign tout_hit  = (state == ST_REGULATE) && !bus.temp_valid &&
                       (tout_cnt == TCNT_W'(TIMEOUT_CYC - 1));
    assign fault_hit = otemp_hit || tout_hit;
    // Disable has priority over any fault raised in the same cycle.
    assign run = enable && ((state == ST_DISABLED) ||
                            (state == ST_REGULATE && !fault_hit));

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state       <= ST_DISABLED;
            heating     <= 1'b0;
            tout_cause  <= 1'b0;
            otemp_cause <= 1'b0;
            alarm_q     <= 1'b0;
            last_sample <= '0;
            target      <= '0;
            alarm_cnt   <= '0;
            tout_cnt    <= '0;
        end else begin
            case (state)
                ST_DISABLED: begin
                    heating     <= 1'b0;
                    last_sample <= '0;
                    target      <= '0;
                    alarm_cnt   <= '0;
                    tout_cnt    <= '0;
                    if (enable) state <= ST_REGULATE;
                end
                ST_REGULATE: begin
                    if (!enable) begin
                        state       <= ST_DISABLED;
                        heating     <= 1'b0;
                        last_sample <= '0;
                        target      <= '0;
                        alarm_cnt   <= '0;
                        tout_cnt    <= '0;
                    end else begin
                        if (bus.temp_valid) begin
                            last_sample <= temp;
                            heating     <= heat_nx;
                            target      <= target_nx;
                            alarm_cnt   <= over ? acnt_inc : '0;
                            tout_cnt    <= '0;
                        end else begin
                            tout_cnt <= tout_cnt + 1'b1;
                        end
                        if (fault_hit) begin
                            state       <= ST_FAULT;
                            alarm_q     <= 1'b1;
                            tout_cause  <= tout_hit;
                            otemp_cause <= otemp_hit;
                            heating     <= 1'b0;
                            target      <= '0;
                            alarm_cnt   <= '0;
                            tout_cnt    <= '0;
                        end
                    end
                end
                ST_FAULT: begin
                    alarm_cnt <= '0;
                    tout_cnt  <= '0;
                    if (!enable) begin
                        state       <= ST_DISABLED;
                        alarm_q     <= 1'b0;
                        tout_cause  <= 1'b0;
                        otemp_cause <= 1'b0;
                        last_sample <= '0;
                    end
                end
                default: state <= ST_DISABLED;
            endcase
        end
    end

    temp_pwm_gen #(
        .PWM_PERIOD (PWM_PERIOD),
        .DUTY_W     (DUTY_W)
    ) u_pwm (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .run         (run),
        .duty_target (target),
        .pwm         (bus.heater_pwm)
    );

    assign bus.alarm  = alarm_q;
    assign bus.status = {16'(last_sample), 11'd0, otemp_cause, tout_cause, heating, state};
endmodule

// File: tb/tb_temp_control_core.sv
module tb_temp_control_core;
    import temp_ctrl_pkg::*;

    localparam int P = 10;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    temp_ctrl_if #(.TEMP_W(16)) bus ();

    temp_control_core #(
        .TEMP_W      (16),
        .PWM_PERIOD  (P),
        .KP_SHIFT    (4),
        .ALARM_CNT   (3),
        .TIMEOUT_CYC (50)
    ) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus)
    );

    typedef struct {
        logic        mode;
        logic [15:0] sp;
        logic [15:0] hyst;
        logic [7:0]  kp;
        logic [15:0] temp;
        logic        flag;
        int          highs;
    } vec_t;

    vec_t vecs[14];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_regs(input logic mode, input logic [15:0] sp, input logic [15:0] hyst,
                            input logic [7:0] kp, input logic [15:0] lim, input logic en);
        bus.ctrl_reg     = {30'd0, mode, en};
        bus.setpoint_reg = {16'd0, sp};
        bus.hyst_reg     = {8'd0, kp, hyst};
        bus.limit_reg    = {16'd0, lim};
    endtask

    task automatic sample(input logic [15:0] t);
        bus.temp_data  = t;
        bus.temp_valid = 1'b1;
        tick();
        bus.temp_valid = 1'b0;
    endtask

    // Ticks until status reports FAULT, bounded; returns the tick count (or -1).
    task automatic wait_fault(output int k);
        k = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (bus.status[1:0] == STATE_FAULT) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        int bad;
        int highs;
        int k;

        vecs[0]  = '{1'b0, 16'd100, 16'd5, 8'd0,  16'd90,  1'b1, 10};
        vecs[1]  = '{1'b0, 16'd100, 16'd5, 8'd0,  16'd97,  1'b1, 10};
        vecs[2]  = '{1'b0, 16'd100, 16'd5, 8'd0,  16'd104, 1'b1, 10};
        vecs[3]  = '{1'b0, 16'd100, 16'd5, 8'd0,  16'd106, 1'b0, 0};
        vecs[4]  = '{1'b0, 16'd100, 16'd5, 8'd0,  16'd100, 1'b0, 0};
        vecs[5]  = '{1'b0, 16'd100, 16'd0, 8'd0,  16'd99,  1'b1, 10};
        vecs[6]  = '{1'b0, 16'd100, 16'd0, 8'd0,  16'd100, 1'b1, 10};
        vecs[7]  = '{1'b0, 16'd100, 16'd0, 8'd0,  16'd101, 1'b0, 0};
        vecs[8]  = '{1'b1, 16'd100, 16'd0, 8'd32, 16'd97,  1'b1, 6};
        vecs[9]  = '{1'b1, 16'd100, 16'd0, 8'd32, 16'd90,  1'b1, 10};
        vecs[10] = '{1'b1, 16'd100, 16'd0, 8'd32, 16'd105, 1'b0, 0};
        vecs[11] = '{1'b1, 16'd100, 16'd0, 8'd32, 16'd95,  1'b1, 10};
        vecs[12] = '{1'b1, 16'd100, 16'd0, 8'd32, 16'd99,  1'b1, 2};
        vecs[13] = '{1'b1, 16'hFFF6, 16'd0, 8'd32, 16'hFFF3, 1'b1, 6};

        bus.temp_valid = 1'b0;
        bus.temp_data  = 16'd123;
        set_regs(1'b0, 16'd200, 16'd5, 8'd0, 16'd1000, 1'b0);

        // Reset and disabled streaming
        repeat (3) tick();
        chk("rst_heater", {31'd0, bus.heater_pwm}, 32'd0);
        chk("rst_alarm", {31'd0, bus.alarm}, 32'd0);
        chk("rst_status", bus.status, 32'd0);
        ARESET = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            bus.temp_valid = i[0];
            tick();
            if (bus.heater_pwm !== 1'b0 || bus.alarm !== 1'b0 || bus.status !== 32'd0) bad++;
        end
        bus.temp_valid = 1'b0;
        chk("disabled_idle_bad_cycles", bad, 0);

        // Enter REGULATE
        set_regs(1'b0, 16'd100, 16'd5, 8'd0, 16'd1000, 1'b1);
        tick();
        chk("enter_regulate", {30'd0, bus.status[1:0]}, {30'd0, STATE_REGULATE});

        // Table of samples: heating flag, last sample and high cycles per period
        foreach (vecs[i]) begin
            set_regs(vecs[i].mode, vecs[i].sp, vecs[i].hyst, vecs[i].kp, 16'd1000, 1'b1);
            sample(vecs[i].temp);
            chk($sformatf("vec%0d_flag", i), {31'd0, bus.status[STAT_HEAT]}, {31'd0, vecs[i].flag});
            chk($sformatf("vec%0d_sample", i), {16'd0, bus.status[31:16]}, {16'd0, vecs[i].temp});
            repeat (20) tick();
            highs = 0;
            for (int c = 0; c < P; c++) begin
                tick();
                if (bus.heater_pwm === 1'b1) highs++;
            end
            chk($sformatf("vec%0d_highs", i), highs, vecs[i].highs);
        end

        // Overtemp: 151,152,149,151,151,151 against limit 150
        set_regs(1'b0, 16'd200, 16'd5, 8'd0, 16'd150, 1'b1);
        sample(16'd151); repeat (12) tick();
        sample(16'd152); repeat (12) tick();
        sample(16'd149);
        chk("ot_no_fault_s3", {29'd0, bus.alarm, bus.status[1:0]}, {29'd0, 1'b0, STATE_REGULATE});
        repeat (12) tick();
        sample(16'd151); repeat (12) tick();
        sample(16'd151); repeat (12) tick();
        chk("ot_no_fault_s5", {29'd0, bus.alarm, bus.status[1:0]}, {29'd0, 1'b0, STATE_REGULATE});
        chk("ot_heater_before", {31'd0, bus.heater_pwm}, 32'd1);
        sample(16'd151);
        chk("ot_fault_status", bus.status, {16'd151, 11'd0, 5'b10010});
        chk("ot_alarm", {31'd0, bus.alarm}, 32'd1);
        chk("ot_heater_off", {31'd0, bus.heater_pwm}, 32'd0);
        bus.ctrl_reg = 32'd0;
        tick();
        chk("ot_cleared_status", bus.status, 32'd0);
        chk("ot_cleared_alarm", {31'd0, bus.alarm}, 32'd0);

        // Timeout with no samples
        bus.ctrl_reg = 32'd1;
        tick();
        wait_fault(k);
        chk("tout_cycles", k, 50);
        chk("tout_causes", {27'd0, bus.status[4:0]}, {27'd0, 5'b01010});
        chk("tout_alarm", {31'd0, bus.alarm}, 32'd1);
        bus.ctrl_reg = 32'd0;
        tick();
        bus.ctrl_reg = 32'd1;
        tick();
        repeat (49) tick();
        sample(16'd100);
        chk("tout_postponed", {30'd0, bus.status[1:0]}, {30'd0, STATE_REGULATE});
        wait_fault(k);
        chk("tout_after_sample", k, 50);
        bus.ctrl_reg = 32'd0;
        tick();

        // Asynchronous reset with heater high
        bus.ctrl_reg = 32'd1;
        tick();
        sample(16'd100);
        repeat (20) tick();
        chk("ar_heater_before", {31'd0, bus.heater_pwm}, 32'd1);
        #3;
        ARESET = 1'b1;
        #1;
        chk("ar_heater_async", {31'd0, bus.heater_pwm}, 32'd0);
        chk("ar_status_async", bus.status, 32'd0);
        tick();
        ARESET = 1'b0;
        #1;
        chk("ar_disabled_after", {30'd0, bus.status[1:0]}, {30'd0, STATE_DISABLED});
        tick();
        chk("ar_reenter", {30'd0, bus.status[1:0]}, {30'd0, STATE_REGULATE});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
